// File: rtl/dpd_gain_lut.sv
`default_nettype none
// ============================================================================
// Module   : dpd_gain_lut
// Purpose  : Amplitude-indexed complex gain lookup for the DPD datapath.
//            Each accepted I/Q sample is squared to instantaneous power, the
//            power is quantised to a table address and the stored complex
//            coefficient is read out next to the delay-matched sample, so
//            {out_iq, out_coef} feed the downstream complex multiplier
//            directly. After reset the table fills itself with unity gain.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            in_valid/in_iq     - input sample {I, Q}, accepted with in_ready
//            in_ready           - high in RUN (table initialised)
//            coef_we/addr/data  - software coefficient write port (RUN only)
//            bypass             - force unity coefficient at the output
//            out_valid/out_iq   - delay-matched sample
//            out_coef           - coefficient for out_iq
//            init_done          - table initialisation complete
// Revision : 1.0 - initial release
// ============================================================================
module dpd_gain_lut #(
  parameter int W  = 20,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  in_iq,
  input  logic            coef_we,
  input  logic [AW-1:0]   coef_addr,
  input  logic [2*W-1:0]  coef_data,
  input  logic            bypass,
  output logic            out_valid,
  output logic [2*W-1:0]  out_iq,
  output logic [2*W-1:0]  out_coef,
  output logic            init_done
);

  localparam int DEPTH = 1 << AW;

  // Unity gain in Q(W-1): I = 2^(W-1)-1, Q = 0.
  localparam logic [2*W-1:0] C_UNITY = {1'b0, {(W-1){1'b1}}, {W{1'b0}}};

  // --------------------------------------------------------------------------
  // Control FSM: INIT sweeps the table writing unity, RUN serves samples.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_init_cnt;
  logic [AW-1:0]   w_init_cnt_nxt;
  logic            w_run;
  logic            w_ram_we;
  logic [AW-1:0]   w_ram_addr;
  logic [2*W-1:0]  w_ram_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_run          = 1'b0;
    w_ram_we       = 1'b0;
    w_ram_addr     = coef_addr;
    w_ram_wdata    = coef_data;
    case (r_state)
      ST_INIT: begin
        w_ram_we       = 1'b1;
        w_ram_addr     = r_init_cnt;
        w_ram_wdata    = C_UNITY;
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == {AW{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run    = 1'b1;
        w_ram_we = coef_we;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign in_ready  = w_run;
  assign init_done = w_run;

  // --------------------------------------------------------------------------
  // Coefficient table. Not reset: INIT rewrites every entry. Reset blocks the
  // write so it wins over a coincident coef_we.
  // --------------------------------------------------------------------------
  logic [2*W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (!reset && w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // s1: register accepted sample
  // --------------------------------------------------------------------------
  logic            w_accept;
  logic            r1_valid;
  logic [W-1:0]    r1_i;
  logic [W-1:0]    r1_q;

  assign w_accept = in_valid & w_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid <= 1'b0;
    end else begin
      r1_valid <= w_accept;
    end
    r1_i <= in_iq[2*W-1:W];
    r1_q <= in_iq[W-1:0];
  end

  // --------------------------------------------------------------------------
  // s2: instantaneous power p = I^2 + Q^2. Operands are sign-extended to 2W
  // so the low 2W bits of each product are the exact square (<= 2^(2W-2)).
  // --------------------------------------------------------------------------
  logic signed [2*W-1:0] w_i_ext;
  logic signed [2*W-1:0] w_q_ext;
  logic signed [2*W-1:0] w_i_sq;
  logic signed [2*W-1:0] w_q_sq;
  logic        [2*W-1:0] w_pwr;
  logic                  r2_valid;
  logic        [2*W-1:0] r2_iq;
  logic        [2*W-1:0] r2_pwr;

  assign w_i_ext = {{W{r1_i[W-1]}}, r1_i};
  assign w_q_ext = {{W{r1_q[W-1]}}, r1_q};
  assign w_i_sq  = w_i_ext * w_i_ext;
  assign w_q_sq  = w_q_ext * w_q_ext;
  assign w_pwr   = w_i_sq + w_q_sq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r2_valid <= 1'b0;
    end else begin
      r2_valid <= r1_valid;
    end
    r2_iq  <= {r1_i, r1_q};
    r2_pwr <= w_pwr;
  end

  // --------------------------------------------------------------------------
  // s3: quantise power to an address. Powers at or above 2^(2W-2) (either of
  // the top two bits set) saturate to the last entry; below that the address
  // is the truncated top AW bits of the remaining range.
  // --------------------------------------------------------------------------
  logic            w_sat;
  logic [AW-1:0]   w_addr;
  logic            r3_valid;
  logic [2*W-1:0]  r3_iq;
  logic [AW-1:0]   r3_addr;

  assign w_sat  = |r2_pwr[2*W-1:2*W-2];
  assign w_addr = w_sat ? {AW{1'b1}} : r2_pwr[2*W-3 -: AW];

  always_ff @(posedge clk) begin
    if (reset) begin
      r3_valid <= 1'b0;
    end else begin
      r3_valid <= r2_valid;
    end
    r3_iq   <= r2_iq;
    r3_addr <= w_addr;
  end

  // --------------------------------------------------------------------------
  // s4: synchronous table read. The non-blocking write above makes a read of
  // the address written on the same edge return the old entry.
  // Outputs hold their last values across bubbles.
  // --------------------------------------------------------------------------
  logic            r_out_valid;
  logic [2*W-1:0]  r_out_iq;
  logic [2*W-1:0]  r_out_coef;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_iq    <= '0;
      r_out_coef  <= '0;
    end else begin
      r_out_valid <= r3_valid;
      if (r3_valid) begin
        r_out_iq   <= r3_iq;
        r_out_coef <= bypass ? C_UNITY : r_mem[r3_addr];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_iq    = r_out_iq;
  assign out_coef  = r_out_coef;

endmodule
`default_nettype wire

// File: tb/tb_dpd_gain_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpd_gain_lut
// Purpose  : Directed self-checking bench for dpd_gain_lut. Expected
//            {sample, coefficient} pairs are queued when a sample is driven
//            and compared when the DUT presents out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpd_gain_lut;

  localparam int W  = 20;
  localparam int AW = 8;
  localparam logic [39:0] U      = 40'h7FFFF_00000;
  localparam logic [39:0] C64_A  = 40'h12345_54321;
  localparam logic [39:0] C64_B  = 40'hABCDE_0F0F0;
  localparam logic [39:0] C255   = 40'h00001_00002;
  localparam logic [39:0] JUNK   = 40'hDEAD0_BEEF0;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [39:0]    in_iq;
  logic           coef_we;
  logic [AW-1:0]  coef_addr;
  logic [39:0]    coef_data;
  logic           bypass;
  logic           out_valid;
  logic [39:0]    out_iq;
  logic [39:0]    out_coef;
  logic           init_done;

  dpd_gain_lut #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_iq     (in_iq),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_iq    (out_iq),
    .out_coef  (out_coef),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] iq;
    logic [39:0] coef;
  } exp_t;

  exp_t        sb[$];
  logic [39:0] lut_m [0:255];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference address: p = I^2 + Q^2, saturate at 2^38, else bits [37:30].
  function automatic int model_addr(input logic [39:0] iq);
    longint i;
    longint q;
    longint p;
    i = longint'($signed(iq[39:20]));
    q = longint'($signed(iq[19:0]));
    p = i * i + q * q;
    if (p >= (longint'(1) << 38)) return 255;
    return int'((p >> 30) & 255);
  endfunction

  function automatic logic [39:0] exp_coef(input logic [39:0] iq);
    if (bypass) return U;
    return lut_m[model_addr(iq)];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 256; k++) lut_m[k] = U;
  endtask

  task automatic send(input logic [39:0] iq);
    in_valid = 1'b1;
    in_iq    = iq;
    sb.push_back('{iq: iq, coef: exp_coef(iq)});
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [39:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    lut_m[a]  = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Bounded wait for in_ready; returns cycles spent low (400 = timed out).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Output monitor: pops the scoreboard on every out_valid.
  always begin
    @(posedge clk);
    #2;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_iq", 64'(out_iq), 64'(e.iq));
        check("out_coef", 64'(out_coef), 64'(e.coef));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_iq     = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    bypass    = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_iq", 64'(out_iq), 64'd0);
    check("rst_out_coef", 64'(out_coef), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);

    // INIT: in_valid and coef_we must be ignored throughout
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_iq     = 40'h40000_00000;
    coef_we   = 1'b1;
    coef_addr = 8'd16;
    coef_data = JUNK;
    wait_ready(cnt);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    check("init_cycles", 64'(cnt), 64'd256);
    check("init_done", 64'(init_done), 64'd1);

    // Unity after init (addr 4 and addr 16 which saw the ignored write)
    send(40'h10000_00000);
    send(40'h20000_00000);
    drain(6);

    // Software coefficient + latency
    write_coef(8'd64, C64_A);
    in_valid = 1'b1;
    in_iq    = 40'h40000_00000;
    sb.push_back('{iq: 40'h40000_00000, coef: exp_coef(40'h40000_00000)});
    @(negedge clk);
    in_valid = 1'b0;
    check("lat1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat2", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat3", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat4", 64'(out_valid), 64'd1);
    drain(4);

    // Saturation to address 255
    write_coef(8'd255, C255);
    send(40'h80000_80000);
    send(40'h7FFFF_00000);
    send(40'h80000_00000);
    drain(6);

    // Read-first collision: A reads 64 on the same edge it is rewritten
    in_valid = 1'b1;
    in_iq    = 40'h40000_00000;
    sb.push_back('{iq: 40'h40000_00000, coef: C64_A});
    @(negedge clk);
    in_iq    = 40'h40000_00001;
    sb.push_back('{iq: 40'h40000_00001, coef: C64_B});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    write_coef(8'd64, C64_B);
    drain(6);

    // Bypass forces unity
    bypass = 1'b1;
    send(40'h40000_00000);
    send(40'h80000_80000);
    drain(6);
    bypass = 1'b0;

    // Stream 1,0,1,1 with distinct addresses; outputs hold through bubbles
    send(40'h40000_00000);
    in_valid = 1'b0;
    in_iq    = 40'h11111_22222;
    @(negedge clk);
    send(40'h80000_00000);
    send(40'h20000_20000);
    in_valid = 1'b0;
    check("strm_v0", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("strm_v1", 64'(out_valid), 64'd0);
    check("strm_hold_iq", 64'(out_iq), 64'h40000_00000);
    check("strm_hold_coef", 64'(out_coef), 64'(C64_B));
    @(negedge clk);
    check("strm_v2", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("strm_v3", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("strm_v4", 64'(out_valid), 64'd0);
    check("strm_tail_iq", 64'(out_iq), 64'h20000_20000);
    drain(3);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset with three samples in flight (not expected at the output)
    in_valid = 1'b1;
    in_iq    = 40'h40000_00000;
    @(negedge clk);
    in_iq    = 40'h80000_80000;
    @(negedge clk);
    in_iq    = 40'h10000_00000;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    model_reset();
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd0);
    wait_ready(cnt);
    check("reinit_cycles", 64'(cnt), 64'd256);
    send(40'h40000_00000);
    drain(6);
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
